// File: rtl/d16_stack_if.sv
// Operation/status bundle between the d16 execute stage (master) and a stack unit (slave).
// One operation is applied per clock edge; there is no valid/ready handshake.
interface d16_stack_if #(
  parameter int WIDTH      = 16,
  parameter int DEPTH_LOG2 = 6
);
  logic [2:0]            i_op;
  logic [WIDTH-1:0]      i_dat;
  logic [DEPTH_LOG2-1:0] i_pick_idx;
  logic                  i_clr_err;
  logic [WIDTH-1:0]      o_tos;
  logic [WIDTH-1:0]      o_nos;
  logic [WIDTH-1:0]      o_pick;
  logic                  o_pick_vld;
  logic [DEPTH_LOG2:0]   o_sp;
  logic                  o_empty;
  logic                  o_full;
  logic                  o_ovf;
  logic                  o_unf;

  modport master (
    output i_op, i_dat, i_pick_idx, i_clr_err,
    input  o_tos, o_nos, o_pick, o_pick_vld, o_sp, o_empty, o_full, o_ovf, o_unf
  );

  modport slave (
    input  i_op, i_dat, i_pick_idx, i_clr_err,
    output o_tos, o_nos, o_pick, o_pick_vld, o_sp, o_empty, o_full, o_ovf, o_unf
  );
endinterface

// File: rtl/d16_stack.sv
// Parametrised d16 data/return stack: register array, bounds-checked ops, sticky
// overflow/underflow flags, asynchronous TOS/NOS/pick reads.
module d16_stack #(
  parameter int WIDTH      = 16,
  parameter int DEPTH_LOG2 = 6
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  d16_stack_if.slave  bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int SPW   = DEPTH_LOG2 + 1;

  typedef enum logic [2:0] {
    OP_NOP      = 3'd0,
    OP_PUSH     = 3'd1,
    OP_POP      = 3'd2,
    OP_POP2     = 3'd3,
    OP_REPL_T   = 3'd4,
    OP_POP_REPL = 3'd5,
    OP_SWAP     = 3'd6,
    OP_SETSP    = 3'd7
  } op_e;

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [SPW-1:0]        sp_q, sp_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;

  op_e                   op;
  logic [SPW-1:0]        sp_m1, sp_m2, pick_pos;
  logic [DEPTH_LOG2-1:0] idx_t, idx_n;
  logic                  has1, has2, not_full;
  logic                  set_ovf, set_unf;
  logic                  we_a, we_b;
  logic [DEPTH_LOG2-1:0] idx_a, idx_b;
  logic [WIDTH-1:0]      dat_a, dat_b;

  assign op       = op_e'(bus.i_op);
  assign sp_m1    = sp_q - SPW'(1);
  assign sp_m2    = sp_q - SPW'(2);
  assign idx_t    = sp_m1[DEPTH_LOG2-1:0];
  assign idx_n    = sp_m2[DEPTH_LOG2-1:0];
  assign has1     = (sp_q >= SPW'(1));
  assign has2     = (sp_q >= SPW'(2));
  assign not_full = (sp_q < SPW'(DEPTH));
  assign pick_pos = sp_m1 - {1'b0, bus.i_pick_idx};

  always_comb begin
    sp_d    = sp_q;
    set_ovf = 1'b0;
    set_unf = 1'b0;
    we_a    = 1'b0;
    we_b    = 1'b0;
    idx_a   = idx_t;
    idx_b   = idx_n;
    dat_a   = bus.i_dat;
    dat_b   = bus.i_dat;
    case (op)
      OP_NOP: ;
      OP_PUSH: begin
        if (not_full) begin
          we_a  = 1'b1;
          idx_a = sp_q[DEPTH_LOG2-1:0];
          sp_d  = sp_q + SPW'(1);
        end else begin
          set_ovf = 1'b1;
        end
      end
      OP_POP: begin
        if (has1) sp_d = sp_m1;
        else      set_unf = 1'b1;
      end
      OP_POP2: begin
        if (has2) sp_d = sp_m2;
        else      set_unf = 1'b1;
      end
      OP_REPL_T: begin
        if (has1) we_a = 1'b1;
        else      set_unf = 1'b1;
      end
      OP_POP_REPL: begin
        if (has2) begin
          we_b = 1'b1;
          sp_d = sp_m1;
        end else begin
          set_unf = 1'b1;
        end
      end
      OP_SWAP: begin
        // Both ports read the pre-edge contents, so the exchange is atomic.
        if (has2) begin
          we_a  = 1'b1;
          we_b  = 1'b1;
          dat_a = mem_q[idx_n];
          dat_b = mem_q[idx_t];
        end else begin
          set_unf = 1'b1;
        end
      end
      OP_SETSP: sp_d = {1'b0, bus.i_dat[DEPTH_LOG2-1:0]};
      default: ;
    endcase
    // A new violation wins over a simultaneous clear.
    ovf_d = (ovf_q & ~bus.i_clr_err) | set_ovf;
    unf_d = (unf_q & ~bus.i_clr_err) | set_unf;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      sp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset_n) begin
      if (we_a) mem_q[idx_a] <= dat_a;
      if (we_b) mem_q[idx_b] <= dat_b;
    end
  end

  assign bus.o_tos      = has1 ? mem_q[idx_t] : '0;
  assign bus.o_nos      = has2 ? mem_q[idx_n] : '0;
  assign bus.o_pick_vld = ({1'b0, bus.i_pick_idx} < sp_q);
  assign bus.o_pick     = bus.o_pick_vld ? mem_q[pick_pos[DEPTH_LOG2-1:0]] : '0;
  assign bus.o_sp       = sp_q;
  assign bus.o_empty    = (sp_q == '0);
  assign bus.o_full     = (sp_q == SPW'(DEPTH));
  assign bus.o_ovf      = ovf_q;
  assign bus.o_unf      = unf_q;
endmodule

// File: tb/tb_d16_stack.sv
// Bench for d16_stack: a 16x64 and a 32x8 instance driven by directed and random ops,
// compared against an array/counter model of the stack rules.
module tb_d16_stack;
  logic clk = 1'b0;
  logic rst_n0, rst_n1;
  always #5 clk = ~clk;

  d16_stack_if #(.WIDTH(16), .DEPTH_LOG2(6)) bus0 ();
  d16_stack_if #(.WIDTH(32), .DEPTH_LOG2(3)) bus1 ();

  d16_stack #(.WIDTH(16), .DEPTH_LOG2(6)) dut0 (.i_clk(clk), .i_reset_n(rst_n0), .bus(bus0));
  d16_stack #(.WIDTH(32), .DEPTH_LOG2(3)) dut1 (.i_clk(clk), .i_reset_n(rst_n1), .bus(bus1));

  int checks   = 0;
  int failures = 0;

  // Reference model: unit 0 = 16-bit x 64, unit 1 = 32-bit x 8.
  logic [31:0] mm [2][64];
  int          ms   [2];
  bit          movf [2];
  bit          munf [2];

  function automatic int dep(input int u);
    return (u == 0) ? 64 : 8;
  endfunction

  function automatic logic [31:0] wmask(input int u);
    return (u == 0) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
  endfunction

  task automatic model_step(input int u, input int op, input logic [31:0] dat, input bit clr);
    bit so, su;
    logic [31:0] d, t;
    so = 0; su = 0;
    d = dat & wmask(u);
    case (op)
      1: if (ms[u] < dep(u)) begin mm[u][ms[u]] = d; ms[u]++; end else so = 1;
      2: if (ms[u] >= 1) ms[u]--; else su = 1;
      3: if (ms[u] >= 2) ms[u] -= 2; else su = 1;
      4: if (ms[u] >= 1) mm[u][ms[u]-1] = d; else su = 1;
      5: if (ms[u] >= 2) begin mm[u][ms[u]-2] = d; ms[u]--; end else su = 1;
      6: if (ms[u] >= 2) begin
           t = mm[u][ms[u]-1]; mm[u][ms[u]-1] = mm[u][ms[u]-2]; mm[u][ms[u]-2] = t;
         end else su = 1;
      7: ms[u] = int'(dat) & (dep(u) - 1);
      default: ;
    endcase
    movf[u] = (movf[u] && !clr) || so;
    munf[u] = (munf[u] && !clr) || su;
  endtask

  task automatic cmp(input string tag, input string field, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, field, obs, exp);
    end
  endtask

  task automatic set_nop();
    bus0.i_op = 3'd0; bus0.i_dat = '0; bus0.i_clr_err = 1'b0;
    bus1.i_op = 3'd0; bus1.i_dat = '0; bus1.i_clr_err = 1'b0;
  endtask

  task automatic drive(input int u, input int op, input logic [31:0] dat, input bit clr);
    logic [2:0] op3;
    op3 = op[2:0];
    if (u == 0) begin
      bus0.i_op = op3; bus0.i_dat = dat[15:0]; bus0.i_clr_err = clr;
    end else begin
      bus1.i_op = op3; bus1.i_dat = dat; bus1.i_clr_err = clr;
    end
    @(posedge clk);
    #1;
    model_step(u, op, dat, clr);
    set_nop();
  endtask

  // Synchronous reset applied while a PUSH is presented: reset must win.
  task automatic do_reset(input int u, input logic [31:0] dat);
    if (u == 0) begin
      rst_n0 = 1'b0; bus0.i_op = 3'd1; bus0.i_dat = dat[15:0];
    end else begin
      rst_n1 = 1'b0; bus1.i_op = 3'd1; bus1.i_dat = dat;
    end
    @(posedge clk);
    #1;
    ms[u] = 0; movf[u] = 0; munf[u] = 0;
    if (u == 0) rst_n0 = 1'b1; else rst_n1 = 1'b1;
    set_nop();
  endtask

  task automatic check_unit(input int u, input string tag, input int pidx);
    logic [31:0] tos, nos, pick, sp, e_pick;
    logic        vld, emp, ful, ovf, unf;
    bit          e_vld;
    if (u == 0) bus0.i_pick_idx = pidx[5:0]; else bus1.i_pick_idx = pidx[2:0];
    #1;
    if (u == 0) begin
      tos = 32'(bus0.o_tos); nos = 32'(bus0.o_nos); pick = 32'(bus0.o_pick); sp = 32'(bus0.o_sp);
      vld = bus0.o_pick_vld; emp = bus0.o_empty; ful = bus0.o_full; ovf = bus0.o_ovf; unf = bus0.o_unf;
    end else begin
      tos = bus1.o_tos; nos = bus1.o_nos; pick = bus1.o_pick; sp = 32'(bus1.o_sp);
      vld = bus1.o_pick_vld; emp = bus1.o_empty; ful = bus1.o_full; ovf = bus1.o_ovf; unf = bus1.o_unf;
    end
    e_vld  = (pidx < ms[u]);
    e_pick = e_vld ? mm[u][ms[u]-1-pidx] : 32'h0;
    cmp(tag, "sp",    sp,  32'(ms[u]));
    cmp(tag, "tos",   tos, (ms[u] >= 1) ? mm[u][ms[u]-1] : 32'h0);
    cmp(tag, "nos",   nos, (ms[u] >= 2) ? mm[u][ms[u]-2] : 32'h0);
    cmp(tag, "pick",  pick, e_pick);
    cmp(tag, "vld",   32'(vld), 32'(e_vld));
    cmp(tag, "empty", 32'(emp), 32'(ms[u] == 0));
    cmp(tag, "full",  32'(ful), 32'(ms[u] == dep(u)));
    cmp(tag, "ovf",   32'(ovf), 32'(movf[u]));
    cmp(tag, "unf",   32'(unf), 32'(munf[u]));
  endtask

  task automatic random_ops(input int u, input int n);
    int op;
    for (int i = 0; i < n; i++) begin
      op = $urandom_range(0, 7);
      if (op == 7 && $urandom_range(0, 3) != 0) op = 1;
      drive(u, op, $urandom, ($urandom_range(0, 9) == 0));
      check_unit(u, $sformatf("rand%0d_%0d", u, i), $urandom_range(0, dep(u) - 1));
    end
  endtask

  initial begin
    rst_n0 = 1'b0; rst_n1 = 1'b0;
    set_nop();
    bus0.i_pick_idx = '0; bus1.i_pick_idx = '0;
    for (int u = 0; u < 2; u++) begin ms[u] = 0; movf[u] = 0; munf[u] = 0; end
    repeat (2) @(posedge clk);
    #1;
    rst_n0 = 1'b1; rst_n1 = 1'b1;
    check_unit(0, "reset0", 0);
    check_unit(1, "reset1", 0);

    // Three pushes, pick inside and just past the stack.
    drive(0, 1, 32'h1111, 0);
    drive(0, 1, 32'h2222, 0);
    drive(0, 1, 32'h3333, 0);
    check_unit(0, "push3_pick2", 2);
    check_unit(0, "push3_pick3", 3);
    drive(0, 6, 32'h0, 0);
    check_unit(0, "swap", 1);
    drive(0, 5, 32'h5555, 0);
    check_unit(0, "pop_repl", 1);

    // Fill to DEPTH, then overflow, pop, clear.
    while (ms[0] < 64) drive(0, 1, $urandom, 0);
    check_unit(0, "filled", 63);
    drive(0, 1, 32'hBEEF, 0);
    check_unit(0, "ovf_push", 0);
    drive(0, 2, 32'h0, 0);
    check_unit(0, "pop_after_ovf", 5);
    drive(0, 0, 32'h0, 1);
    check_unit(0, "clr_ovf", 5);

    // Underflow path.
    drive(0, 7, 32'h0001, 0);
    drive(0, 3, 32'h0, 0);
    check_unit(0, "pop2_unf", 0);
    drive(0, 2, 32'h0, 0);
    drive(0, 2, 32'h0, 0);
    check_unit(0, "pop_to_empty", 0);
    drive(0, 4, 32'h7777, 0);
    check_unit(0, "repl_t_empty", 0);

    // SETSP uses only the low index bits; set beats clear.
    drive(0, 7, 32'hFF05, 0);
    check_unit(0, "setsp", 4);
    drive(0, 0, 32'h0, 1);
    check_unit(0, "clr_unf", 0);
    drive(0, 7, 32'h0000, 0);
    drive(0, 2, 32'h0, 1);
    check_unit(0, "unf_beats_clr", 0);

    random_ops(0, 300);

    // Reset during PUSH at sp=10 with ovf set.
    while (ms[0] < 64) drive(0, 1, $urandom, 0);
    drive(0, 1, 32'hABCD, 0);
    drive(0, 7, 32'd10, 0);
    check_unit(0, "pre_reset", 9);
    do_reset(0, 32'h4242);
    check_unit(0, "reset_mid_push", 0);

    // 32-bit x 8 instance.
    for (int i = 0; i < 8; i++) drive(1, 1, {16'hC0DE, 8'(i), 8'($urandom)}, 0);
    check_unit(1, "w32_full", 7);
    drive(1, 1, 32'hDEAD_BEEF, 0);
    check_unit(1, "w32_ovf", 3);
    random_ops(1, 120);
    drive(1, 7, 32'hFFFF_FFF9, 0);
    check_unit(1, "w32_setsp", 0);
    do_reset(1, 32'h1234_5678);
    check_unit(1, "w32_reset", 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
